// File: rtl/axis_width_downsizer.sv
// axis_width_downsizer
// Splits each wide AXI4-Stream beat into RATIO narrow slices, least-significant
// slice first. Empty trailing slices of a beat are skipped; a beat with no
// kept bytes still emits slice 0, so tlast is never lost. Non-last beats that
// are not fully kept are counted in a saturating debug counter.
module axis_width_downsizer #(
   parameter int S_DATA_WIDTH  = 512,
   parameter int M_DATA_WIDTH  = 256,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [S_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [S_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic                       s_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [M_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [M_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic [ERR_CNT_WIDTH-1:0]   err_keep_cnt
);

   localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
   localparam int SK    = S_DATA_WIDTH / 8;
   localparam int MK    = M_DATA_WIDTH / 8;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;

   // Held wide beat and slice bookkeeping; r_last_idx is the index of the
   // final slice to emit (number of slices minus one).
   logic [S_DATA_WIDTH-1:0]   r_data;
   logic [SK-1:0]             r_keep;
   logic                      r_last;
   logic [IDX_W-1:0]          r_idx;
   logic [IDX_W-1:0]          r_last_idx;
   logic                      r_rdy_en;

   // Registered output slice
   logic [M_DATA_WIDTH-1:0]   r_m_data;
   logic [MK-1:0]             r_m_keep;
   logic                      r_m_last;
   logic [ERR_CNT_WIDTH-1:0]  r_err_cnt;

   logic [M_DATA_WIDTH-1:0]   w_hold_data [RATIO];
   logic [MK-1:0]             w_hold_keep [RATIO];
   logic [RATIO-1:0]          w_in_any;
   logic [IDX_W-1:0]          w_cap_last_idx;
   logic [IDX_W-1:0]          w_idx_inc;
   logic                      w_m_xfer;
   logic                      w_final;
   logic                      w_cap;
   logic                      w_bad_keep;

   // Per-slice views of the held beat and per-slice occupancy of the input keep
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
         assign w_hold_data[gi] = r_data[gi*M_DATA_WIDTH +: M_DATA_WIDTH];
         assign w_hold_keep[gi] = r_keep[gi*MK +: MK];
         assign w_in_any[gi]    = |s_axis_tkeep[gi*MK +: MK];
      end
   endgenerate

   // Index of the highest input slice carrying any byte (0 when keep is empty)
   always_comb begin
      w_cap_last_idx = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (w_in_any[i]) begin
            w_cap_last_idx = IDX_W'(i);
         end
      end
   end

   assign w_idx_inc     = r_idx + 1'b1;
   assign w_m_xfer      = (r_state == ST_HOLD) && m_axis_tready;
   assign w_final       = w_m_xfer && (r_idx == r_last_idx);
   assign s_axis_tready = r_rdy_en && ((r_state == ST_EMPTY) || w_final);
   assign w_cap         = s_axis_tvalid && s_axis_tready;
   assign w_bad_keep    = !s_axis_tlast && (s_axis_tkeep != {SK{1'b1}});

   assign m_axis_tvalid = (r_state == ST_HOLD);
   assign m_axis_tdata  = r_m_data;
   assign m_axis_tkeep  = r_m_keep;
   assign m_axis_tlast  = r_m_last;
   assign err_keep_cnt  = r_err_cnt;

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: a capture always lands in HOLD (even during the final slice),
   // otherwise finishing the final slice empties the holder
   always_comb begin
      w_state_next = r_state;
      if (w_cap) begin
         w_state_next = ST_HOLD;
      end else if (w_final) begin
         w_state_next = ST_EMPTY;
      end
   end

   // Input-ready enable: held low through reset, released on the first edge after
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   // Holding register capture and slice index advance
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_data     <= '0;
         r_keep     <= '0;
         r_last     <= 1'b0;
         r_idx      <= '0;
         r_last_idx <= '0;
      end else if (w_cap) begin
         r_data     <= s_axis_tdata;
         r_keep     <= s_axis_tkeep;
         r_last     <= s_axis_tlast;
         r_idx      <= '0;
         r_last_idx <= w_cap_last_idx;
      end else if (w_m_xfer && !w_final) begin
         r_idx      <= w_idx_inc;
      end
   end

   // Output slice register: slice 0 of a new beat on capture, next slice on advance
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_m_data <= '0;
         r_m_keep <= '0;
         r_m_last <= 1'b0;
      end else if (w_cap) begin
         r_m_data <= s_axis_tdata[M_DATA_WIDTH-1:0];
         r_m_keep <= s_axis_tkeep[MK-1:0];
         r_m_last <= s_axis_tlast && (w_cap_last_idx == '0);
      end else if (w_m_xfer && !w_final) begin
         r_m_data <= w_hold_data[w_idx_inc];
         r_m_keep <= w_hold_keep[w_idx_inc];
         r_m_last <= r_last && (w_idx_inc == r_last_idx);
      end else if (w_final) begin
         r_m_last <= 1'b0;
      end
   end

   // Saturating count of accepted non-last beats that are not fully kept
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_err_cnt <= '0;
      end else if (w_cap && w_bad_keep && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// tb_axis_width_downsizer
// Drives beats from a queue, collects output slices, and compares them with a
// byte-level slicing model built from the input queue.
module tb_axis_width_downsizer;

   localparam int S  = 512;
   localparam int M  = 256;
   localparam int SK = S / 8;
   localparam int MK = M / 8;

   logic           aclk = 1'b0;
   logic           aresetn = 1'b0;
   logic           s_tvalid = 1'b0;
   logic           s_tready;
   logic [S-1:0]   s_tdata = '0;
   logic [SK-1:0]  s_tkeep = '0;
   logic           s_tlast = 1'b0;
   logic           m_tvalid;
   logic           m_tready = 1'b1;
   logic [M-1:0]   m_tdata;
   logic [MK-1:0]  m_tkeep;
   logic           m_tlast;
   logic [15:0]    err_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // stimulus, expectations, observations
   logic [S-1:0]  in_data [$];
   logic [SK-1:0] in_keep [$];
   bit            in_last [$];
   logic [M-1:0]  exp_data [$];
   logic [MK-1:0] exp_keep [$];
   bit            exp_last [$];
   logic [M-1:0]  obs_data [$];
   logic [MK-1:0] obs_keep [$];
   bit            obs_last [$];
   int            obs_cyc [$];
   logic [15:0]   exp_err = '0;
   int            stab_err;
   int            sready_low;
   bit            timed_out;

   axis_width_downsizer #(
      .S_DATA_WIDTH (S),
      .M_DATA_WIDTH (M),
      .ERR_CNT_WIDTH(16)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .err_keep_cnt  (err_cnt)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running, required finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [S-1:0] rand_data();
      logic [S-1:0] d;
      d = '0;
      for (int w = 0; w < S/32; w++) d[w*32 +: 32] = $urandom();
      return d;
   endfunction

   function automatic logic [SK-1:0] rand_keep();
      logic [SK-1:0] k;
      int n;
      k = '0;
      case ($urandom_range(3))
         0: k = '1;
         1: begin
            n = $urandom_range(SK);
            for (int j = 0; j < n; j++) k[j] = 1'b1;
         end
         2: begin
            for (int w = 0; w < SK/32; w++) k[w*32 +: 32] = $urandom();
            if ($urandom_range(1) == 1) k[SK-1:SK/2] = '0;
         end
         default: k = '0;
      endcase
      return k;
   endfunction

   // Reference: a beat yields slices up to the highest one holding any kept
   // byte (at least one); tlast rides on the final slice of a last beat.
   function automatic void build_expected();
      int hi, n;
      logic [S-1:0] d;
      logic [SK-1:0] k;
      exp_data.delete(); exp_keep.delete(); exp_last.delete();
      for (int i = 0; i < in_data.size(); i++) begin
         d = in_data[i];
         k = in_keep[i];
         hi = -1;
         for (int b = 0; b < SK; b++) if (k[b]) hi = b / MK;
         n = (hi < 0) ? 1 : hi + 1;
         for (int s = 0; s < n; s++) begin
            exp_data.push_back(d[s*M +: M]);
            exp_keep.push_back(k[s*MK +: MK]);
            exp_last.push_back(in_last[i] && (s == n - 1));
         end
         if (!in_last[i] && (k != {SK{1'b1}}) && (exp_err != 16'hFFFF)) exp_err = exp_err + 16'd1;
      end
   endfunction

   function automatic void clear_inputs();
      in_data.delete(); in_keep.delete(); in_last.delete();
   endfunction

   function automatic void add_beat(input logic [S-1:0] d, input logic [SK-1:0] k, input bit l);
      in_data.push_back(d); in_keep.push_back(k); in_last.push_back(l);
   endfunction

   // Feeds in_* into the DUT while collecting every output transfer.
   task automatic run_stream(input int rdy_pct, input int budget);
      int deadline;
      int n_exp;
      deadline = cyc + budget;
      n_exp = exp_data.size();
      obs_data.delete(); obs_keep.delete(); obs_last.delete(); obs_cyc.delete();
      stab_err = 0; sready_low = 0; timed_out = 1'b0;
      fork
         begin
            @(posedge aclk); #1;
            for (int i = 0; i < in_data.size(); i++) begin
               s_tvalid = 1'b1; s_tdata = in_data[i]; s_tkeep = in_keep[i]; s_tlast = in_last[i];
               @(negedge aclk);
               while (!s_tready && cyc < deadline) @(negedge aclk);
               @(posedge aclk); #1;
            end
            s_tvalid = 1'b0; s_tlast = 1'b0;
         end
         begin
            logic pv, pr, pl;
            logic [M-1:0] pd;
            logic [MK-1:0] pk;
            pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pk = '0;
            @(posedge aclk); #1;
            while (obs_data.size() < n_exp && cyc < deadline) begin
               m_tready = ($urandom_range(99) < rdy_pct);
               @(negedge aclk);
               if (!s_tready) sready_low++;
               if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl))
                  stab_err++;
               pv = m_tvalid; pr = m_tready; pd = m_tdata; pk = m_tkeep; pl = m_tlast;
               if (m_tvalid && m_tready) begin
                  obs_data.push_back(m_tdata); obs_keep.push_back(m_tkeep);
                  obs_last.push_back(m_tlast); obs_cyc.push_back(cyc);
               end
               @(posedge aclk); #1;
            end
            if (obs_data.size() < n_exp) timed_out = 1'b1;
            m_tready = 1'b1;
         end
      join
   endtask

   task automatic test_reset();
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      n_checks++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
         n_errors++; $display("FAIL reset_valid_last: got %b/%b, required 0/0", m_tvalid, m_tlast);
      end
      n_checks++;
      if (m_tdata !== '0 || m_tkeep !== '0) begin
         n_errors++; $display("FAIL reset_data_keep: got %h/%h, required 0/0", m_tdata, m_tkeep);
      end
      n_checks++;
      if (err_cnt !== 16'd0) begin
         n_errors++; $display("FAIL reset_err: got %0d, required 0", err_cnt);
      end
      n_checks++;
      if (s_tready !== 1'b0) begin
         n_errors++; $display("FAIL reset_sready: got %b, required 0", s_tready);
      end
      aresetn = 1'b1;
      #1;
      n_checks++;
      if (s_tready !== 1'b0) begin
         n_errors++; $display("FAIL release_sready_before_edge: got %b, required 0", s_tready);
      end
      @(posedge aclk); #1;
      n_checks++;
      if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
         n_errors++; $display("FAIL release_sready_after_edge: got %b/%b, required 1/0", s_tready, m_tvalid);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_last_beat();
      logic [S-1:0] d;
      d = rand_data();
      clear_inputs();
      add_beat(d, '1, 1'b1);
      build_expected();
      run_stream(100, 50);
      n_checks++;
      if (obs_data.size() !== 2) begin
         n_errors++; $display("FAIL full_beat_count: got %0d, required 2", obs_data.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            $display("full_beat slice %0d keep %h last %b", i, obs_keep[i], obs_last[i]);
            n_checks++;
            if (obs_data[i] !== d[i*M +: M] || obs_keep[i] !== 32'hFFFF_FFFF || obs_last[i] !== (i == 1)) begin
               n_errors++;
               $display("FAIL full_beat_slice%0d: got keep %h last %b, required keep ffffffff last %b",
                        i, obs_keep[i], obs_last[i], (i == 1));
            end
         end
      end
      n_checks++;
      if (sready_low !== 1) begin
         n_errors++; $display("FAIL full_beat_sready_low: got %0d cycles, required 1", sready_low);
      end
   endtask

   task automatic test_short_last_beat();
      logic [S-1:0] d;
      d = rand_data();
      clear_inputs();
      add_beat(d, 64'h0000_0000_00FF_FFFF, 1'b1);
      build_expected();
      run_stream(100, 50);
      n_checks++;
      if (obs_data.size() !== 1) begin
         n_errors++; $display("FAIL short_beat_count: got %0d, required 1", obs_data.size());
      end else begin
         $display("short_beat slice 0 keep %h last %b", obs_keep[0], obs_last[0]);
         n_checks++;
         if (obs_keep[0] !== 32'h00FF_FFFF || obs_last[0] !== 1'b1 || obs_data[0] !== d[M-1:0]) begin
            n_errors++;
            $display("FAIL short_beat_slice: got keep %h last %b, required keep 00ffffff last 1",
                     obs_keep[0], obs_last[0]);
         end
      end
      n_checks++;
      if (sready_low !== 0) begin
         n_errors++; $display("FAIL short_beat_sready_low: got %0d cycles, required 0", sready_low);
      end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      for (int b = 0; b < 4; b++) add_beat(rand_data(), '1, (b == 3));
      build_expected();
      run_stream(100, 100);
      n_checks++;
      if (obs_data.size() !== 8) begin
         n_errors++; $display("FAIL b2b_count: got %0d, required 8", obs_data.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            $display("b2b slice %0d cycle %0d last %b", i, obs_cyc[i], obs_last[i]);
            n_checks++;
            if (obs_data[i] !== exp_data[i] || obs_keep[i] !== exp_keep[i] || obs_last[i] !== exp_last[i]) begin
               n_errors++;
               $display("FAIL b2b_slice%0d: got keep %h last %b, required keep %h last %b",
                        i, obs_keep[i], obs_last[i], exp_keep[i], exp_last[i]);
            end
            n_checks++;
            if (obs_cyc[i] !== obs_cyc[0] + i) begin
               n_errors++;
               $display("FAIL b2b_bubble%0d: got cycle %0d, required %0d", i, obs_cyc[i], obs_cyc[0] + i);
            end
         end
      end
   endtask

   task automatic test_random_packets();
      int nb;
      int pkt;
      clear_inputs();
      for (int p = 0; p < 1000; p++) begin
         nb = $urandom_range(1, 16);
         for (int b = 0; b < nb; b++) begin
            if (b == nb - 1) add_beat(rand_data(), rand_keep(), 1'b1);
            else             add_beat(rand_data(), '1, 1'b0);
         end
      end
      build_expected();
      run_stream(50, 60000);
      n_checks++;
      if (timed_out !== 1'b0 || obs_data.size() !== exp_data.size()) begin
         n_errors++;
         $display("FAIL random_count: got %0d slices, required %0d", obs_data.size(), exp_data.size());
      end
      pkt = 0;
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
         n_checks++;
         if (obs_data[i] !== exp_data[i] || obs_keep[i] !== exp_keep[i] || obs_last[i] !== exp_last[i]) begin
            n_errors++;
            $display("FAIL random_slice%0d: got keep %h last %b, required keep %h last %b",
                     i, obs_keep[i], obs_last[i], exp_keep[i], exp_last[i]);
         end
         if (exp_last[i]) begin
            $display("random pkt %0d ends at slice %0d", pkt, i);
            pkt++;
         end
      end
      n_checks++;
      if (stab_err !== 0) begin
         n_errors++; $display("FAIL random_stall_stability: got %0d violations, required 0", stab_err);
      end
      n_checks++;
      if (err_cnt !== exp_err) begin
         n_errors++; $display("FAIL random_err_cnt: got %0d, required %0d", err_cnt, exp_err);
      end
   endtask

   task automatic test_sparse_nonlast();
      n_checks++;
      if (err_cnt !== exp_err) begin
         n_errors++; $display("FAIL sparse_err_before: got %0d, required %0d", err_cnt, exp_err);
      end
      clear_inputs();
      add_beat(rand_data(), 64'h0000_FFFF_FFFF_FFFF, 1'b0);
      add_beat(rand_data(), 64'h0000_0000_FFFF_FFFF, 1'b0);
      add_beat(rand_data(), '1, 1'b1);
      build_expected();
      run_stream(100, 100);
      n_checks++;
      if (obs_data.size() !== exp_data.size()) begin
         n_errors++; $display("FAIL sparse_count: got %0d, required %0d", obs_data.size(), exp_data.size());
      end else begin
         for (int i = 0; i < obs_data.size(); i++) begin
            $display("sparse slice %0d keep %h last %b", i, obs_keep[i], obs_last[i]);
            n_checks++;
            if (obs_data[i] !== exp_data[i] || obs_keep[i] !== exp_keep[i] || obs_last[i] !== exp_last[i]) begin
               n_errors++;
               $display("FAIL sparse_slice%0d: got keep %h last %b, required keep %h last %b",
                        i, obs_keep[i], obs_last[i], exp_keep[i], exp_last[i]);
            end
         end
      end
      n_checks++;
      if (err_cnt !== exp_err) begin
         n_errors++; $display("FAIL sparse_err_after: got %0d, required %0d", err_cnt, exp_err);
      end
   endtask

   task automatic test_reset_midpacket();
      logic [S-1:0] d;
      d = rand_data();
      m_tready = 1'b0;
      @(posedge aclk); #1;
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = '1; s_tlast = 1'b1;
      @(posedge aclk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      @(negedge aclk);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== d[M-1:0]) begin
         n_errors++; $display("FAIL midreset_stalled: got valid %b, required 1 with slice 0", m_tvalid);
      end
      aresetn = 1'b0;
      #1;
      exp_err = '0;
      n_checks++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
         n_errors++;
         $display("FAIL midreset_outputs: got valid %b last %b sready %b, required 0 0 0",
                  m_tvalid, m_tlast, s_tready);
      end
      n_checks++;
      if (err_cnt !== 16'd0) begin
         n_errors++; $display("FAIL midreset_err: got %0d, required 0", err_cnt);
      end
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      m_tready = 1'b1;
      @(posedge aclk); #1;
      clear_inputs();
      add_beat(rand_data(), '1, 1'b0);
      add_beat(rand_data(), 64'h0000_00FF_FFFF_FFFF, 1'b1);
      build_expected();
      run_stream(70, 200);
      n_checks++;
      if (obs_data.size() !== exp_data.size()) begin
         n_errors++; $display("FAIL midreset_count: got %0d, required %0d", obs_data.size(), exp_data.size());
      end else begin
         for (int i = 0; i < obs_data.size(); i++) begin
            $display("after_reset slice %0d keep %h last %b", i, obs_keep[i], obs_last[i]);
            n_checks++;
            if (obs_data[i] !== exp_data[i] || obs_keep[i] !== exp_keep[i] || obs_last[i] !== exp_last[i]) begin
               n_errors++;
               $display("FAIL midreset_slice%0d: got keep %h last %b, required keep %h last %b",
                        i, obs_keep[i], obs_last[i], exp_keep[i], exp_last[i]);
            end
         end
      end
      n_checks++;
      if (err_cnt !== exp_err) begin
         n_errors++; $display("FAIL midreset_err_after: got %0d, required %0d", err_cnt, exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_full_last_beat();
      test_short_last_beat();
      test_back_to_back();
      test_random_packets();
      test_sparse_nonlast();
      test_reset_midpacket();
      repeat (3) @(posedge aclk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
